// File: rtl/p_ctrl_pkg.sv
// Shared constants and state encoding for the round controller.
package p_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCopy,
        StIter,
        StRun,
        StDecr,
        StCheck,
        StOut
    } p_state_e;

    // P-unit input mux codes: DIN takes din, X_ keeps the unit's own working value
    localparam logic INPUT_X_  = 1'b0;
    localparam logic INPUT_DIN = 1'b1;

    // Iteration counter MSB; a zero iteration value wraps to 2^(SETTING_MAX+1) rounds
    localparam int unsigned SETTING_MAX = 31;

    // RAM address map
    localparam logic [4:0] PD_ITER_ADDR = 5'd19;
    localparam logic [4:0] PN_ITER_ADDR = 5'd18;
    localparam logic [4:0] PN_RES_ADDR  = 5'd24;

    // Word counts
    localparam int unsigned EK_WORDS   = 18;
    localparam int unsigned LOAD_WORDS = 31;

endpackage

// File: rtl/p_ctrl.sv
// Round controller: loads PD, copies the key schedule into PN, runs the core
// for the loaded iteration count and streams the result words out.
// Optional macro P_CTRL_ZERO_ITER_EN: when defined, ITER goes to CHECK so a loaded
// iteration value of 0 runs no rounds at all.
module p_ctrl
    import p_ctrl_pkg::*;
#(
    parameter int unsigned MSB   = 31,
    parameter int unsigned N_OUT = 6
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [MSB:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [4:0]   PD_addr,
    output logic         PD_wr_en,
    input  logic [MSB:0] PD_out,
    output logic [MSB:0] din,
    output logic         PS_input_select,
    output logic         decr,
    output logic [4:0]   PN_wr_addr,
    output logic [4:0]   PN_addr,
    output logic         PN_wr_en,
    input  logic [MSB:0] PN_out,
    input  logic         ZF,
    output logic         ZF_wr_en,
    output logic         round_start,
    input  logic         round_done,
    output logic         core_owns,
    output logic [MSB:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam logic [4:0] LoadLast = 5'(LOAD_WORDS - 1);
    localparam logic [4:0] EkLast   = 5'(EK_WORDS - 1);
    localparam logic [4:0] OutLast  = 5'(N_OUT - 1);

    p_state_e   state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    // State and word counter registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; every output is forced low while RST is high
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        in_ready        = 1'b0;
        PD_addr         = '0;
        PD_wr_en        = 1'b0;
        din             = '0;
        PS_input_select = INPUT_X_;
        decr            = 1'b0;
        PN_wr_addr      = '0;
        PN_addr         = '0;
        PN_wr_en        = 1'b0;
        ZF_wr_en        = 1'b0;
        round_start     = 1'b0;
        core_owns       = 1'b0;
        out_data        = '0;
        out_valid       = 1'b0;
        busy            = 1'b0;

        if (!RST) begin
            busy = (state_q != StIdle);
            case (state_q)
                StIdle, StLoad: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        PD_addr  = cnt_q;
                        PD_wr_en = 1'b1;
                        din      = in_data;
                        if (cnt_q == LoadLast) begin
                            state_d = StCopy;
                            cnt_d   = '0;
                        end else begin
                            state_d = StLoad;
                            cnt_d   = cnt_q + 5'd1;
                        end
                    end
                end
                StCopy: begin
                    PD_addr         = cnt_q;
                    din             = PD_out;
                    PS_input_select = INPUT_DIN;
                    PN_wr_addr      = cnt_q;
                    PN_wr_en        = 1'b1;
                    if (cnt_q == EkLast) begin
                        state_d = StIter;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                StIter: begin
                    PD_addr         = PD_ITER_ADDR;
                    din             = PD_out;
                    PS_input_select = INPUT_DIN;
                    PN_wr_addr      = PN_ITER_ADDR;
                    PN_wr_en        = 1'b1;
                    ZF_wr_en        = 1'b1;
                    cnt_d           = '0;
`ifdef P_CTRL_ZERO_ITER_EN
                    state_d         = StCheck;
`else
                    state_d         = StRun;
`endif
                end
                StRun: begin
                    // cnt is 0 on entry, so it marks the first RUN cycle
                    core_owns   = 1'b1;
                    round_start = (cnt_q == 5'd0);
                    cnt_d       = 5'd1;
                    if (round_done) begin
                        state_d = StDecr;
                    end
                end
                StDecr: begin
                    decr       = 1'b1;
                    PN_addr    = PN_ITER_ADDR;
                    PN_wr_addr = PN_ITER_ADDR;
                    PN_wr_en   = 1'b1;
                    ZF_wr_en   = 1'b1;
                    state_d    = StCheck;
                end
                StCheck: begin
                    cnt_d   = '0;
                    state_d = ZF ? StOut : StRun;
                end
                StOut: begin
                    PN_addr   = PN_RES_ADDR + cnt_q;
                    out_data  = PN_out;
                    out_valid = 1'b1;
                    if (out_ready) begin
                        if (cnt_q == OutLast) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/p_ctrl.md
P_CTRL -- requirements
Module: p_ctrl

Interface
REQ-001 Parameter MSB, default 31, data MSB; all data ports are MSB+1 bits wide.
REQ-002 Parameter N_OUT, default 6, number of result words read from PN[24..24+N_OUT-1].
REQ-003 CLK  in  1  single clock; all logic rising-edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 in_data/in_valid/in_ready  in/in/out  32/1/1  load stream of 31 data words; transfer when valid&ready.
REQ-006 PD_addr/PD_wr_en  out  5/1  PD RAM address and write enable.
REQ-007 PD_out  in  32  asynchronous PD read data.
REQ-008 din  out  32  P-unit data input.
REQ-009 PS_input_select/decr  out  1/1  P-unit input mux select and decrement request.
REQ-010 PN_wr_addr/PN_addr/PN_wr_en  out  5/5/1  PN write address, read address and write enable.
REQ-011 PN_out/ZF  in  32/1  PN read data and P-unit zero flag.
REQ-012 ZF_wr_en  out  1  zero-flag update strobe.
REQ-013 round_start/round_done  out/in  1/1  one-cycle round kick to the core; one-cycle completion pulse from the core.
REQ-014 core_owns  out  1  high in RUN only; external mux hands the PD/PN ports to the core.
REQ-015 out_data/out_valid/out_ready  out/out/in  32/1/1  result stream.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, LOAD, COPY, ITER, RUN, DECR, CHECK, OUT; 5-bit word counter cnt.
REQ-018 IDLE/LOAD: in_ready=1; each transfer writes PD[cnt] via PD_wr_en=1, din=in_data, then cnt+1. The first transfer moves IDLE->LOAD. The transfer at cnt=30 clears cnt and moves to COPY.
REQ-019 COPY: 18 cycles, cnt 0..17.
- PD_addr=cnt, din=PD_out, PS_input_select=INPUT_DIN.
- PN_wr_addr=cnt, PN_wr_en=1.
- At cnt=17, go to ITER.
REQ-020 ITER: one cycle. PD_addr=19, din=PD_out, PN_wr_addr=18, PN_wr_en=1, ZF_wr_en=1.
REQ-021 RUN:
- round_start=1 in the first RUN cycle only.
- The controller writes nothing.
- Waits for round_done, then goes to DECR. A round_done arriving in the same cycle as round_start is accepted.
REQ-022 DECR: one cycle. decr=1, PN_addr=18, PN_wr_addr=18, PN_wr_en=1, ZF_wr_en=1; go to CHECK.
REQ-023 CHECK: one cycle. ZF=1 goes to OUT with cnt=0; ZF=0 goes to RUN.
REQ-024 Round count: a loaded iteration value N (N>=1) yields exactly N round_start pulses.
REQ-025 OUT:
- PN_addr=24+cnt, out_data=PN_out, out_valid=1.
- out_data is held stable while out_ready=0.
- Each accepted word increments cnt; the accept at cnt=N_OUT-1 goes to IDLE with cnt=0.
REQ-026 Input handling: in_valid is ignored outside IDLE/LOAD; round_done is ignored outside RUN.
REQ-027 Default outputs: all write enables, decr, ZF_wr_en, round_start and out_valid are 0 in states that do not assert them; all addresses are 0.

Reset
REQ-028 While RST is high the FSM enters IDLE and clears cnt. All outputs are 0 during RST, including in_ready and busy.
REQ-029 in_ready=1 in the first cycle after RST falls.
REQ-030 RST in any state, including mid-LOAD and mid-OUT, aborts with no further RAM writes; partial PD/PN contents are don't-care.

Configuration
REQ-031 Macro P_CTRL_ZERO_ITER_EN.
- Defined: ITER goes to CHECK, so a loaded value 0 gives zero rounds and goes straight to OUT.
- Undefined: ITER goes to RUN, and a loaded 0 wraps to 2^(SETTING_MAX+1) rounds.

Structure
REQ-032 The state encoding, INPUT_DIN/INPUT_X_ codes, SETTING_MAX and the address constants live in the shared bcrypt header:
- PD_ITER_ADDR=19
- PN_ITER_ADDR=18
- PN_RES_ADDR=24
- EK_WORDS=18
- LOAD_WORDS=31
REQ-033 The block is a single module with no sub-modules.

Verification
REQ-034 Load 31 words 0x100+i with in_valid held high -> PD[i]=0x100+i, COPY starts 31 cycles after the first transfer, PN[0..17]=0x100..0x111.
REQ-035 Iteration value 3, round_done returned 5 cycles after each round_start -> exactly 3 round_start pulses, PN[18] reads 2,1,0, OUT entered after the third CHECK.
REQ-036 OUT with PN[24..29]=0xA0..0xA5 and out_ready toggling 1,0,1,... -> six words 0xA0..0xA5 in order, stable while stalled, busy=0 afterwards.
REQ-037 Iteration value 0 -> with the macro: zero round_start pulses and OUT follows CHECK; without it: round_start pulses continue past 2^(SETTING_MAX+1)-1 and PN[18] wraps to all-ones.
REQ-038 RST asserted mid-LOAD (word 12) and at OUT word 3 -> next cycle IDLE, all outputs 0 during RST, a fresh 31-word load then completes correctly.
